// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan driver.
package seg_pkg;

  // One hex digit of the displayed value.
  typedef logic [3:0] nibble_t;

  // All segments dark (active-low cathodes).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low hex font, seg[0]=a .. seg[6]=g; entry 15 listed first.
  localparam logic [15:0][6:0] SEG_FONT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg_scan_driver_if.sv
// Data-in / display-pins bundle for seg_scan_driver.
interface seg_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BRIGHT_W   = 3
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    load;
  logic                    blank_lz;
  logic [BRIGHT_W-1:0]     bright;
  logic [6:0]              seg;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_start;

  // Score/game logic side.
  modport master (
    output value, dp, load, blank_lz, bright,
    input  seg, dp_n, an, frame_start
  );

  // Display driver side.
  modport slave (
    input  value, dp, load, blank_lz, bright,
    output seg, dp_n, an, frame_start
  );
endinterface

// File: rtl/seg_font_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg_font_decode
  import seg_pkg::*;
(
  input  nibble_t    nib_i,
  output logic [6:0] seg_o
);

  // Straight table lookup.
  always_comb begin
    seg_o = SEG_FONT[nib_i];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with guard time, PWM
// brightness, leading-zero blanking and frame-boundary (tear-free) updates.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned REFRESH_HZ = 1000,
  parameter int unsigned GUARD      = 16,
  parameter int unsigned BRIGHT_W   = 3
) (
  input logic              clk,
  input logic              rst_n,
  seg_scan_driver_if.slave bus
);

  localparam int unsigned DIV    = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int          STEP   = (int'(DIV) - int'(GUARD)) / ((2 ** BRIGHT_W) - 1);
  localparam int unsigned StepU  = unsigned'(STEP);
  localparam int unsigned CntW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DigW   = $clog2(NUM_DIGITS);
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);
  localparam logic [DigW-1:0] DigMax = DigW'(NUM_DIGITS - 1);
  localparam logic [BRIGHT_W-1:0] BrightMax = '1;

  if (STEP < 1) begin : gen_step_check
    $error("seg_scan_driver: slot too short for guard plus brightness steps (STEP < 1)");
  end

  logic [CntW-1:0] div_cnt_q, div_cnt_d;
  logic [DigW-1:0] digit_q, digit_d;
  nibble_t [NUM_DIGITS-1:0] stage_val_q, stage_val_d, disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0] stage_dp_q, stage_dp_d, disp_dp_q, disp_dp_d;
  logic [6:0] seg_q, seg_d;
  logic dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic frame_start_q, frame_start_d;

  logic wrap;
  logic [NUM_DIGITS-1:0] blank_vec;
  logic upper_zero;
  logic [6:0] font_seg;
  logic pwm_on;
  int unsigned cnt_ext, on_end;

  assign wrap = (div_cnt_q == CntMax) && (digit_q == DigMax);

  // Slot counter and digit index.
  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    digit_d   = digit_q;
    if (div_cnt_q == CntMax) begin
      div_cnt_d = '0;
      digit_d   = (digit_q == DigMax) ? '0 : digit_q + 1'b1;
    end
  end

  // Staging takes every load; display only changes at the frame wrap, and a
  // load on the wrap cycle itself goes straight through.
  always_comb begin
    stage_val_d = bus.load ? bus.value : stage_val_q;
    stage_dp_d  = bus.load ? bus.dp : stage_dp_q;
    disp_val_d  = wrap ? stage_val_d : disp_val_q;
    disp_dp_d   = wrap ? stage_dp_d : disp_dp_q;
  end

  // Leading-zero blanking: digit d>0 is blank when it and all higher digits are 0.
  always_comb begin
    upper_zero = 1'b1;
    blank_vec  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (disp_val_q[i] == 4'h0);
      if (i != 0) blank_vec[i] = bus.blank_lz & upper_zero;
    end
  end

  seg_font_decode u_font (
    .nib_i (disp_val_q[digit_q]),
    .seg_o (font_seg)
  );

  // PWM window inside the slot; full brightness runs to the end of the slot.
  always_comb begin
    cnt_ext = 32'(div_cnt_q);
    on_end  = GUARD + 32'(bus.bright) * StepU;
    pwm_on  = (cnt_ext >= GUARD) && ((bus.bright == BrightMax) || (cnt_ext < on_end));
  end

  // Next values of the registered pin outputs.
  always_comb begin
    an_d = '1;
    if (pwm_on) an_d[digit_q] = 1'b0;
    seg_d         = blank_vec[digit_q] ? SEG_OFF : font_seg;
    dp_n_d        = blank_vec[digit_q] ? 1'b1 : ~disp_dp_q[digit_q];
    frame_start_d = wrap;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      digit_q       <= '0;
      stage_val_q   <= '0;
      stage_dp_q    <= '0;
      disp_val_q    <= '0;
      disp_dp_q     <= '0;
      seg_q         <= SEG_OFF;
      dp_n_q        <= 1'b1;
      an_q          <= '1;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      digit_q       <= digit_d;
      stage_val_q   <= stage_val_d;
      stage_dp_q    <= stage_dp_d;
      disp_val_q    <= disp_val_d;
      disp_dp_q     <= disp_dp_d;
      seg_q         <= seg_d;
      dp_n_q        <= dp_n_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.dp_n        = dp_n_q;
  assign bus.an          = an_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: DIV=8, GUARD=1, STEP=1.
module tb_seg_scan_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_tests = 0;
  int n_fail = 0;

  seg_scan_driver_if #(.NUM_DIGITS(4), .BRIGHT_W(3)) bus ();

  seg_scan_driver #(
    .NUM_DIGITS (4),
    .CLK_HZ     (3200),
    .REFRESH_HZ (100),
    .GUARD      (1),
    .BRIGHT_W   (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_tests++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Checks one 8-cycle slot of digit d; optionally pulses load at cycle load_at.
  task automatic check_slot(input int d, input logic [6:0] exp_seg, input logic exp_dpn,
                            input int br, input int load_at, input logic [15:0] load_val);
    for (int c = 0; c < 8; c++) begin
      logic [3:0] exp_an;
      logic on;
      @(negedge clk);
      on = (c >= 1) && ((br == 7) || (c < 1 + br));
      exp_an = 4'hF;
      if (on) exp_an[d] = 1'b0;
      chk($sformatf("an d%0d c%0d", d, c), 16'(bus.an), 16'(exp_an));
      chk($sformatf("seg d%0d c%0d", d, c), 16'(bus.seg), 16'(exp_seg));
      chk($sformatf("dp_n d%0d c%0d", d, c), 16'(bus.dp_n), 16'(exp_dpn));
      chk($sformatf("frame_start d%0d c%0d", d, c), 16'(bus.frame_start),
          16'((d == 3) && (c == 7)));
      if (c == load_at) begin
        bus.load  = 1'b1;
        bus.value = load_val;
      end else if (c == load_at + 1) begin
        bus.load = 1'b0;
      end
    end
  endtask

  // segs packed {d3,d2,d1,d0}, dpn bit per digit.
  task automatic check_frame(input logic [27:0] segs, input logic [3:0] dpn, input int br);
    for (int d = 0; d < 4; d++) check_slot(d, segs[d*7 +: 7], dpn[d], br, -1, 16'h0);
  endtask

  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.frame_start === 1'b1) seen = 1'b1;
    end
    chk("frame_start timeout", 16'(seen), 16'h1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    bus.value = v;
    bus.dp    = d;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  initial begin
    bus.value    = '0;
    bus.dp       = '0;
    bus.load     = 1'b0;
    bus.blank_lz = 1'b0;
    bus.bright   = 3'd7;
    #2 rst_n = 1'b0;

    // 1. Reset and basic scan.
    repeat (3) @(negedge clk);
    chk("reset an", 16'(bus.an), 16'hF);
    chk("reset seg", 16'(bus.seg), 16'h7F);
    chk("reset dp_n", 16'(bus.dp_n), 16'h1);
    chk("reset frame_start", 16'(bus.frame_start), 16'h0);
    rst_n = 1'b1;
    do_load(16'h1234, 4'b0000);
    wait_frame();
    check_frame({7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 7);

    // 2. Leading-zero blanking, then blanking disabled.
    bus.blank_lz = 1'b1;
    do_load(16'h0050, 4'b0010);
    wait_frame();
    check_frame({7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1101, 7);
    bus.blank_lz = 1'b0;
    wait_frame();
    check_frame({7'h40, 7'h40, 7'h12, 7'h40}, 4'b1101, 7);

    // 3. All-zero value keeps digit 0 lit.
    bus.blank_lz = 1'b1;
    do_load(16'h0000, 4'b0000);
    wait_frame();
    check_frame({7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF, 7);

    // 4. Brightness 0 and 3.
    bus.bright = 3'd0;
    wait_frame();
    check_frame({7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF, 0);
    bus.bright = 3'd3;
    wait_frame();
    check_frame({7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF, 3);

    // 5a. Load during digit 1 does not disturb the running frame.
    bus.bright   = 3'd7;
    bus.blank_lz = 1'b0;
    do_load(16'h1234, 4'b0000);
    wait_frame();
    check_slot(0, 7'h19, 1'b1, 7, -1, 16'h0);
    bus.value = 16'hABCD;
    bus.load  = 1'b1;
    check_slot(1, 7'h30, 1'b1, 7, -1, 16'h0);
    check_slot(2, 7'h24, 1'b1, 7, -1, 16'h0);
    check_slot(3, 7'h79, 1'b1, 7, -1, 16'h0);

    // 5b. New data shows next frame; a load on the wrap cycle goes straight in.
    check_slot(0, 7'h21, 1'b1, 7, -1, 16'h0);
    check_slot(1, 7'h46, 1'b1, 7, -1, 16'h0);
    check_slot(2, 7'h03, 1'b1, 7, -1, 16'h0);
    check_slot(3, 7'h08, 1'b1, 7, 6, 16'h0F8D);
    check_frame({7'h40, 7'h0E, 7'h00, 7'h21}, 4'hF, 7);

    // 6. Asynchronous reset during digit 2's on window.
    repeat (20) @(negedge clk);
    chk("pre-reset an", 16'(bus.an), 16'b1011);
    chk("pre-reset seg", 16'(bus.seg), 16'h0E);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset an", 16'(bus.an), 16'hF);
    chk("async reset seg", 16'(bus.seg), 16'h7F);
    chk("async reset dp_n", 16'(bus.dp_n), 16'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset guard an", 16'(bus.an), 16'hF);
    chk("post-reset seg", 16'(bus.seg), 16'h40);
    @(negedge clk);
    chk("post-reset first an", 16'(bus.an), 16'b1110);
    chk("post-reset first seg", 16'(bus.seg), 16'h40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Parametrised, time-multiplexed driver for a NUM_DIGITS common-anode 7-segment display. It latches a packed hex value with decimal points and scans one digit per slot, with these added features:
- inter-digit guard (anti-ghost) time
- PWM brightness control
- optional leading-zero blanking
- tear-free frame-boundary update

It sits between game/score logic and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=2)
CLK_HZ, 100000000, input clock frequency
REFRESH_HZ, 1000, full-frame refresh rate
GUARD, 16, cycles at the start of each slot with all anodes off
BRIGHT_W, 3, brightness control width
Derived localparams:
- DIV = CLK_HZ/(REFRESH_HZ*NUM_DIGITS), the cycles per digit slot.
- STEP = (DIV-GUARD)/(2**BRIGHT_W-1).
- Elaboration fails if STEP < 1.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
value  in  4*NUM_DIGITS  packed hex digits; digit i = value[4i+3:4i]; digit 0 least significant
dp  in  NUM_DIGITS  decimal point request per digit, active-high
load  in  1  capture value/dp this cycle
blank_lz  in  1  enable leading-zero blanking
bright  in  BRIGHT_W  brightness; 0 = dark, all-ones = full
seg  out  7  segment cathodes, active-low, seg[0]=a .. seg[6]=g
dp_n  out  1  decimal point cathode, active-low
an  out  NUM_DIGITS  digit anodes, active-low, an[i] drives digit i
frame_start  out  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Outputs: seg=all ones, dp_n=1, an=all ones, frame_start=0.
  - State: div_cnt=0, digit index=0, staging and display registers=0.
- div_cnt counts 0..DIV-1.
- At div_cnt=DIV-1, the digit index advances modulo NUM_DIGITS.
  - When it wraps from NUM_DIGITS-1 to 0, this is the "wrap" cycle.
- Tear-free update:
  - load=1 writes value/dp into the staging register.
  - On the wrap cycle, the display register takes the staging register.
  - If load=1 on the wrap cycle, the display register takes the input value/dp directly; the new data is shown from digit 0 of the new frame.
  - load mid-frame never changes the current frame.
- Anode enable for the current digit d is "on" when GUARD <= div_cnt < GUARD + bright*STEP.
  - bright = all-ones extends the on window to DIV-1 inclusive.
  - bright=0 keeps all anodes off.
  - At most one anode is low at any time.
- Segment decode uses the standard active-low hex font:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex, seg[6:0])
- Leading-zero blanking:
  - If blank_lz=1, digit d>0 is blanked when all display digits d..NUM_DIGITS-1 are 0.
  - Digit 0 is never blanked.
  - A blanked digit drives seg=all ones and dp_n=1; its anode timing is unchanged.
- dp_n = ~dp_disp[d] for unblanked digits.
- Output timing:
  - seg, dp_n, an and frame_start are registered.
  - They reflect the div_cnt/digit state of the previous cycle, so latency is 1 cycle.
  - frame_start is high exactly 1 cycle per frame.
- Reset mid-frame:
  - Outputs go off immediately (asynchronous).
  - After release, the scan restarts at digit 0, div_cnt=0, with a blank display (value 0: digit 0 shows 40).

Decomposition:
- Package seg_pkg holds:
  - the 16-entry active-low font constant
  - the SEG_OFF = 7'h7F constant
  - the digit-nibble typedef
- One combinational sub-module, seg_font_decode (4-bit nibble in, 7-bit active-low seg out), implements the font.
- The scan counter, staging/display registers, blanking logic and PWM compare stay in seg_scan_driver.

Test Plan:
All scenarios use bench parameters NUM_DIGITS=4, CLK_HZ=3200, REFRESH_HZ=100, GUARD=1, BRIGHT_W=3, giving DIV=8 and STEP=1.

1. Reset and basic scan.
   Stimulus: hold rst_n=0, then release; load=1 with value=16'h1234, bright=7.
   Required response: during reset an=4'hF, seg=7F, dp_n=1. After the next frame_start, an=4'b1110 shows seg=19, 4'b1101 shows 30, 4'b1011 shows 24, 4'b0111 shows 79. Each anode is low 7 of 8 cycles, and high for 1 guard cycle between digits.
2. Leading-zero blanking.
   Stimulus: value=16'h0050, blank_lz=1, dp=4'b0010.
   Required response: digits 3 and 2 show seg=7F, dp_n=1. Digit 1 shows seg=12, dp_n=0. Digit 0 shows seg=40. With blank_lz=0, digits 3 and 2 show 40.
3. All-zero value.
   Stimulus: value=0, blank_lz=1.
   Required response: only digit 0 shows 40; digits 1-3 show 7F.
4. Brightness control.
   Stimulus: bright=0, then bright=3.
   Required response: bright=0 gives an=4'hF for a whole frame. bright=3 gives each anode low for exactly 3 consecutive cycles per 8-cycle slot, starting at the 2nd cycle of the slot.
5. Tear-free update.
   - Stimulus: load value=16'hABCD during digit 1 of a frame. Required response: digits 2 and 3 of that frame still show the old data; the new data appears after frame_start.
   - Stimulus: load=1 on the wrap cycle. Required response: digit 0 of the new frame shows the new value (D gives seg=21).
6. Reset mid-frame.
   Stimulus: assert rst_n=0 during digit 2 while its anode is low.
   Required response: an=4'hF and seg=7F in the same cycle without waiting for a clock edge. After release, the first active anode is an[0], showing 40.
